// File: rtl/riscv_pkg.sv
// Shared RV64I constants, immediate formats and the ID/EX control bundle.
// Imported by the decode/issue stage and its immediate generator.
package riscv_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } immFmt_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       regWrite;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       illegal;
    } idExCtrl_t;

endpackage

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for the RV64I instruction formats.
// The opcode bits play no part, so only instruction[31:7] is taken.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7]     instr,
    input  immFmt_t         fmt,
    output logic [XLEN-1:0] imm
);

    logic sign;
    assign sign = instr[31];

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{(XLEN-12){sign}}, instr[31:20]};
            IMM_S: imm = {{(XLEN-12){sign}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{(XLEN-12){sign}}, instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            IMM_U: imm = {{(XLEN-32){sign}}, instr[31:12], 12'b0};
            IMM_J: imm = {{(XLEN-20){sign}}, instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_stage.sv
// RV64I decode/issue stage: holding slot, RAW scoreboard, hazard FSM
// and a registered ID/EX output slot.
module decode_issue_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inValid,
    output logic            inReady,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pcIn,
    input  logic            flush,
    output logic [4:0]      readRegister1,
    output logic [4:0]      readRegister2,
    input  logic            wbRegWrite,
    input  logic [4:0]      wbRegister,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] outPc,
    output logic [4:0]      outRd,
    output logic            outRegWrite,
    output logic [6:0]      outOpcode,
    output logic [2:0]      outFunct3,
    output logic [6:0]      outFunct7,
    output logic [XLEN-1:0] outImm,
    output logic            outIllegal,
    output logic [15:0]     stallCycles
);

    typedef enum logic [1:0] {EMPTY, HELD, STALL} state_t;

    state_t          state, stateNext;
    logic [31:0]     slotInstr;
    logic [XLEN-1:0] slotPc;
    logic [31:0]     pending, pendingNext;
    idExCtrl_t       outCtrl, ctrl;
    logic [XLEN-1:0] imm;

    logic    slotValid, load, issue, hazard;
    logic    legal, usesRs1, usesRs2, noWrite, regWrite;
    immFmt_t fmt;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;

    assign opcode = slotInstr[6:0];
    assign rd     = slotInstr[11:7];
    assign rs1    = slotInstr[19:15];
    assign rs2    = slotInstr[24:20];

    assign readRegister1 = rs1;
    assign readRegister2 = rs2;

    always_comb begin
        fmt     = IMM_NONE;
        legal   = 1'b1;
        usesRs1 = 1'b1;
        usesRs2 = 1'b0;
        noWrite = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                fmt     = IMM_U;
                usesRs1 = 1'b0;
            end
            OP_JAL: begin
                fmt     = IMM_J;
                usesRs1 = 1'b0;
            end
            OP_JALR, OP_LOAD, OP_IMM, OP_IMM32: fmt = IMM_I;
            OP_BRANCH: begin
                fmt     = IMM_B;
                usesRs2 = 1'b1;
                noWrite = 1'b1;
            end
            OP_STORE: begin
                fmt     = IMM_S;
                usesRs2 = 1'b1;
                noWrite = 1'b1;
            end
            OP_OP, OP_OP32: usesRs2 = 1'b1;
            default: begin
                legal   = 1'b0;
                usesRs1 = 1'b0;
            end
        endcase
    end

    assign regWrite = legal && !noWrite && (rd != 5'd0);

    imm_gen uImmGen (
        .instr (slotInstr[31:7]),
        .fmt   (fmt),
        .imm   (imm)
    );

    always_comb begin
        ctrl          = '0;
        ctrl.rd       = rd;
        ctrl.regWrite = regWrite;
        ctrl.opcode   = opcode;
        ctrl.funct3   = slotInstr[14:12];
        ctrl.funct7   = slotInstr[31:25];
        ctrl.illegal  = !legal;
    end

    assign slotValid = (state != EMPTY);
    assign hazard    = (usesRs1 && pending[rs1]) || (usesRs2 && pending[rs2]);
    assign issue     = slotValid && !hazard && (!outValid || outReady) && !flush;
    assign inReady   = !slotValid || issue;
    assign load      = inValid && inReady && !flush;

    always_comb begin
        stateNext = state;
        case (state)
            EMPTY: if (load) stateNext = HELD;
            HELD, STALL: begin
                if (issue)       stateNext = load ? HELD : EMPTY;
                else if (hazard) stateNext = STALL;
                else             stateNext = HELD;
            end
            default: stateNext = EMPTY;
        endcase
        if (flush) stateNext = EMPTY;
    end

    // Clears first so a same-cycle issue to the same register keeps it pending.
    always_comb begin
        pendingNext = pending;
        if (wbRegWrite) pendingNext[wbRegister] = 1'b0;
        if (flush && outValid && outCtrl.regWrite) pendingNext[outCtrl.rd] = 1'b0;
        if (issue && regWrite) pendingNext[rd] = 1'b1;
        pendingNext[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            slotInstr   <= '0;
            slotPc      <= '0;
            pending     <= '0;
            outValid    <= 1'b0;
            outCtrl     <= '0;
            outPc       <= '0;
            outImm      <= '0;
            stallCycles <= '0;
        end else begin
            state   <= stateNext;
            pending <= pendingNext;
            if (load) begin
                slotInstr <= instruction;
                slotPc    <= pcIn;
            end
            if (issue) begin
                outValid <= 1'b1;
                outCtrl  <= ctrl;
                outPc    <= slotPc;
                outImm   <= imm;
            end else if (flush || outReady) begin
                outValid <= 1'b0;
            end
            if (slotValid && hazard && stallCycles != 16'hFFFF)
                stallCycles <= stallCycles + 16'd1;
        end
    end

    assign outRd       = outCtrl.rd;
    assign outRegWrite = outCtrl.regWrite;
    assign outOpcode   = outCtrl.opcode;
    assign outFunct3   = outCtrl.funct3;
    assign outFunct7   = outCtrl.funct7;
    assign outIllegal  = outCtrl.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed RV64I vectors with
// hand-derived expectations, checked by a separate output monitor.
module tb_decode_issue_stage;
    import riscv_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            inValid;
    logic            inReady;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pcIn;
    logic            flush;
    logic [4:0]      readRegister1, readRegister2;
    logic            wbRegWrite;
    logic [4:0]      wbRegister;
    logic            outValid;
    logic            outReady;
    logic [XLEN-1:0] outPc;
    logic [4:0]      outRd;
    logic            outRegWrite;
    logic [6:0]      outOpcode;
    logic [2:0]      outFunct3;
    logic [6:0]      outFunct7;
    logic [XLEN-1:0] outImm;
    logic            outIllegal;
    logic [15:0]     stallCycles;

    decode_issue_stage dut (
        .clk           (clk),
        .rst           (rst),
        .inValid       (inValid),
        .inReady       (inReady),
        .instruction   (instruction),
        .pcIn          (pcIn),
        .flush         (flush),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .wbRegWrite    (wbRegWrite),
        .wbRegister    (wbRegister),
        .outValid      (outValid),
        .outReady      (outReady),
        .outPc         (outPc),
        .outRd         (outRd),
        .outRegWrite   (outRegWrite),
        .outOpcode     (outOpcode),
        .outFunct3     (outFunct3),
        .outFunct7     (outFunct7),
        .outImm        (outImm),
        .outIllegal    (outIllegal),
        .stallCycles   (stallCycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [6:0]  op;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic expect_out(input logic [63:0] pc, input logic [4:0] rd,
                              input logic rw, input logic [6:0] op,
                              input logic [63:0] imm, input logic ill);
        exp_t e;
        e.pc = pc; e.rd = rd; e.rw = rw; e.op = op; e.imm = imm; e.ill = ill;
        expQ.push_back(e);
    endtask

    // Offer one instruction; returns 1ns after the edge that accepted it.
    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        instruction = ins;
        pcIn = pc;
        inValid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = inReady;
            @(posedge clk);
            #1;
            n++;
        end
        inValid = 1'b0;
        if (!acc) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: pc %h never accepted", pc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && outValid && outReady) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_issue: pc %h with empty scoreboard", outPc);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (outPc !== e.pc || outRd !== e.rd || outRegWrite !== e.rw ||
                    outOpcode !== e.op || outImm !== e.imm || outIllegal !== e.ill) begin
                    mismatched++;
                    $display("FAIL issue_fields: got pc=%h rd=%0d rw=%b op=%h imm=%h ill=%b expected pc=%h rd=%0d rw=%b op=%h imm=%h ill=%b",
                             outPc, outRd, outRegWrite, outOpcode, outImm, outIllegal,
                             e.pc, e.rd, e.rw, e.op, e.imm, e.ill);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0;
        rst = 1'b1; inValid = 1'b0; instruction = '0; pcIn = '0;
        flush = 1'b0; wbRegWrite = 1'b0; wbRegister = '0; outReady = 1'b1;
        #12;
        chk("reset_inReady", 64'(inReady), 64'd1);
        chk("reset_rr1", 64'(readRegister1), 64'd0);
        chk("reset_outValid", 64'(outValid), 64'd0);
        chk("reset_stall", 64'(stallCycles), 64'd0);
        chk("reset_outImm", outImm, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // RAW stall: addi x5,x0,7 then add x6,x5,x5
        expect_out(64'h100, 5'd5, 1'b1, 7'h13, 64'd7, 1'b0);
        send(32'h00700293, 64'h100);
        expect_out(64'h104, 5'd6, 1'b1, 7'h33, 64'd0, 1'b0);
        send(32'h00528333, 64'h104);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_rr1", 64'(readRegister1), 64'd5);
        chk("stall_inReady", 64'(inReady), 64'd0);
        wbRegWrite = 1'b1; wbRegister = 5'd5;
        @(posedge clk); #1;
        wbRegWrite = 1'b0;
        chk("stall_count", 64'(stallCycles), 64'd4);
        chk("stall_not_issued", 64'(outValid), 64'd0);
        @(posedge clk); #1;
        chk("issue_after_wb", 64'(outValid), 64'd1);
        @(posedge clk); #1;
        chk("stall_count_hold", 64'(stallCycles), 64'd4);

        // Back-to-back independent addi x(10+i),x0,i
        t0 = $time;
        for (int i = 1; i <= 4; i++) begin
            logic [31:0] ins;
            ins = (32'(i) << 20) | (32'(10 + i) << 7) | 32'h13;
            expect_out(64'h200 + 64'(4 * i), 5'(10 + i), 1'b1, 7'h13, 64'(i), 1'b0);
            send(ins, 64'h200 + 64'(4 * i));
        end
        chk("stream_cycles", 64'($time - t0), 64'd40);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: full slot and full output for 3 cycles
        outReady = 1'b0;
        expect_out(64'h300, 5'd16, 1'b1, 7'h13, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(32'hFFF00813, 64'h300);
        expect_out(64'h304, 5'd17, 1'b1, 7'h13, 64'h7FF, 1'b0);
        send(32'h7FF00893, 64'h304);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_inReady", 64'(inReady), 64'd0);
            chk("bp_outPc", outPc, 64'h300);
        end
        @(posedge clk); #1;
        outReady = 1'b1;

        // beq -4, illegal opcode, lui sign extension
        expect_out(64'h400, 5'd29, 1'b0, 7'h63, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send(32'hFE000EE3, 64'h400);
        expect_out(64'h404, 5'd0, 1'b0, 7'h7F, 64'd0, 1'b1);
        send(32'h0000007F, 64'h404);
        expect_out(64'h408, 5'd8, 1'b1, 7'h37, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send(32'h80000437, 64'h408);
        repeat (3) @(posedge clk);
        #1;

        // Flush an issued lw x7 sitting in the output register
        outReady = 1'b0;
        send(32'h00002383, 64'h500);
        @(posedge clk); #1;
        chk("lw_outValid", 64'(outValid), 64'd1);
        chk("lw_pending7", 64'(dut.pending[7]), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_outValid", 64'(outValid), 64'd0);
        chk("flush_pending7", 64'(dut.pending[7]), 64'd0);
        outReady = 1'b1;
        expect_out(64'h504, 5'd9, 1'b1, 7'h33, 64'd0, 1'b0);
        send(32'h007384B3, 64'h504);
        @(posedge clk); #1;
        chk("flush_no_stall", 64'(stallCycles), 64'd4);

        // Same-cycle writeback of x5 and issue writing x5
        expect_out(64'h600, 5'd5, 1'b1, 7'h13, 64'd3, 1'b0);
        send(32'h00300293, 64'h600);
        wbRegWrite = 1'b1; wbRegister = 5'd5;
        @(posedge clk); #1;
        wbRegWrite = 1'b0;
        chk("set_wins_pending5", 64'(dut.pending[5]), 64'd1);
        @(posedge clk); #1;

        // Async reset mid-stall (add x6,x5,x5 never issues)
        send(32'h00528333, 64'h604);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_stall", 64'(stallCycles), 64'd6);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_inReady", 64'(inReady), 64'd1);
        chk("rst_outValid", 64'(outValid), 64'd0);
        chk("rst_rr1", 64'(readRegister1), 64'd0);
        chk("rst_stall", 64'(stallCycles), 64'd0);
        chk("rst_outPc", outPc, 64'd0);
        chk("rst_pending", 64'(dut.pending), 64'd0);
        chk("queue_drained", 64'(expQ.size()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
